// File: rtl/voting_pkg.sv
// Shared definitions for the voting ballot collector slice.
// Holds the default geometry (4 voters, 2-bit ballots, 2-bit IDs), the
// collector state encoding and the ballot typedef used by the collector and
// its register bank.
package voting_pkg;

  localparam int DEF_N_VOTERS = 4;
  localparam int DEF_VOTE_W   = 2;
  localparam int DEF_ID_W     = 2;
  localparam int DEF_TIMEOUT  = 64;
  localparam int BALLOT_VEC_W = DEF_N_VOTERS * DEF_VOTE_W;

  typedef logic [DEF_VOTE_W-1:0] ballot_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/voting_ballot_bank.sv
// Ballot register bank: one VOTE_W-bit slot per voter plus the voted mask.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_wr_en      store i_wr_data into slot i_wr_idx and set its mask bit
//   i_wr_idx     slot index (must be < N_VOTERS when i_wr_en is high)
//   i_wr_data    ballot bits, stored verbatim
//   i_clr        clear every slot and the mask (wins over a write)
//   o_ballots    packed slots, voter k at [VOTE_W*k +: VOTE_W]
//   o_mask       bit k set once slot k was written this round
module voting_ballot_bank
  import voting_pkg::*;
#(
  parameter int N_VOTERS = DEF_N_VOTERS,
  parameter int VOTE_W   = DEF_VOTE_W,
  parameter int ID_W     = DEF_ID_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [ID_W-1:0]            i_wr_idx,
  input  logic [VOTE_W-1:0]          i_wr_data,
  input  logic                       i_clr,
  output logic [N_VOTERS*VOTE_W-1:0] o_ballots,
  output logic [N_VOTERS-1:0]        o_mask
);

  logic [N_VOTERS*VOTE_W-1:0] r_ballots;
  logic [N_VOTERS-1:0]        r_mask;

  // Slot and mask storage; clear has priority over a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ballots <= '0;
      r_mask    <= '0;
    end else if (i_clr) begin
      r_ballots <= '0;
      r_mask    <= '0;
    end else if (i_wr_en) begin
      for (int k = 0; k < N_VOTERS; k++) begin
        if (i_wr_idx == ID_W'(k)) begin
          r_ballots[VOTE_W*k +: VOTE_W] <= i_wr_data;
          r_mask[k]                     <= 1'b1;
        end
      end
    end
  end

  assign o_ballots = r_ballots;
  assign o_mask    = r_mask;

endmodule

// File: rtl/voting_ballot_collector.sv
// Ballot collector in front of the combinational tally stage.
// Takes one ballot per cycle from the voter bus, rejects out-of-range and
// duplicate voter IDs with one-cycle error pulses, and presents the packed
// ballot vector once every voter has voted. The vector is held until the
// consumer accepts it, then the bank is cleared and a new round opens.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   vote_valid/vote_ready      voter bus handshake
//   vote_id, vote_data         voter index and ballot bits
//   ballots_valid/ready        handshake towards the tally
//   p_ballots                  packed ballots, voter k at [VOTE_W*k +: VOTE_W]
//   voted_mask                 voters accepted this round
//   err_bad_id, err_dup        one-cycle rejection pulses
//   round_cnt                  completed rounds, wraps at 255
//   timed_out                  only with VOTING_COLLECTOR_TIMEOUT_EN: round
//                              closed by the timeout rather than a full mask
// Build option: VOTING_COLLECTOR_TIMEOUT_EN enables the round timeout.
module voting_ballot_collector
  import voting_pkg::*;
#(
  parameter int N_VOTERS = DEF_N_VOTERS,
  parameter int VOTE_W   = DEF_VOTE_W,
  parameter int ID_W     = DEF_ID_W
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = DEF_TIMEOUT
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vote_valid,
  output logic                       vote_ready,
  input  logic [ID_W-1:0]            vote_id,
  input  logic [VOTE_W-1:0]          vote_data,
  output logic                       ballots_valid,
  input  logic                       ballots_ready,
  output logic [N_VOTERS*VOTE_W-1:0] p_ballots,
  output logic [N_VOTERS-1:0]        voted_mask,
  output logic                       err_bad_id,
  output logic                       err_dup,
  output logic [7:0]                 round_cnt
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
  ,
  output logic                       timed_out
`endif
);

  state_t              r_state;
  state_t              w_next_state;
  logic [N_VOTERS-1:0] w_mask;
  logic [N_VOTERS-1:0] w_id_hot;
  logic                w_hs;
  logic                w_id_ok;
  logic                w_dup;
  logic                w_accept;
  logic                w_close_full;
  logic                w_timeout;
  logic                w_release;
  logic                r_err_bad_id;
  logic                r_err_dup;
  logic [7:0]          r_round_cnt;

  // One-hot decode of the voter ID; an out-of-range ID decodes to all zeros.
  always_comb begin
    w_id_hot = '0;
    for (int k = 0; k < N_VOTERS; k++) begin
      if (vote_id == ID_W'(k)) begin
        w_id_hot[k] = 1'b1;
      end else begin
        w_id_hot[k] = 1'b0;
      end
    end
  end

  assign vote_ready    = (r_state == COLLECT);
  assign ballots_valid = (r_state == PRESENT);
  assign w_hs          = vote_valid & vote_ready;
  assign w_id_ok       = |w_id_hot;
  assign w_dup         = |(w_id_hot & w_mask);
  assign w_accept      = w_hs & w_id_ok & ~w_dup;
  // Accepted ballot fills the last empty slot.
  assign w_close_full  = w_accept & (&(w_mask | w_id_hot));
  assign w_release     = ballots_valid & ballots_ready;

  voting_ballot_bank #(
    .N_VOTERS (N_VOTERS),
    .VOTE_W   (VOTE_W),
    .ID_W     (ID_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_idx  (vote_id),
    .i_wr_data (vote_data),
    .i_clr     (w_release),
    .o_ballots (p_ballots),
    .o_mask    (w_mask)
  );

  assign voted_mask = w_mask;

`ifdef VOTING_COLLECTOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timed_out;

  // Zero means idle; the first accepted ballot loads 1 so the round closes
  // TIMEOUT-1 cycles after that ballot.
  assign w_timeout = (r_state == COLLECT) && (r_to_cnt != '0) &&
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Round timeout counter and the timed-out flag shown during PRESENT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_release) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (r_state == COLLECT) begin
      if (w_accept && (w_mask == '0)) begin
        r_to_cnt <= TO_W'(1);
      end else if (r_to_cnt != '0) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      r_timed_out <= w_timeout & ~w_close_full;
    end
  end

  assign timed_out = r_timed_out;
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: close on a full mask (or timeout), reopen on release.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT: begin
        if (w_close_full || w_timeout) begin
          w_next_state = PRESENT;
        end else begin
          w_next_state = COLLECT;
        end
      end
      PRESENT: begin
        if (ballots_ready) begin
          w_next_state = COLLECT;
        end else begin
          w_next_state = PRESENT;
        end
      end
      default: w_next_state = COLLECT;
    endcase
  end

  // Registered rejection pulses and completed-round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_bad_id <= 1'b0;
      r_err_dup    <= 1'b0;
      r_round_cnt  <= 8'd0;
    end else begin
      r_err_bad_id <= w_hs & ~w_id_ok;
      r_err_dup    <= w_hs & w_id_ok & w_dup;
      if (w_release) begin
        r_round_cnt <= r_round_cnt + 8'd1;
      end
    end
  end

  assign err_bad_id = r_err_bad_id;
  assign err_dup    = r_err_dup;
  assign round_cnt  = r_round_cnt;

endmodule

// File: tb/tb_voting_ballot_collector.sv
module tb_voting_ballot_collector;
  import voting_pkg::*;

  localparam int TO = 8;
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
  localparam int VW = 25;
`else
  localparam int VW = 24;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vote_valid = 1'b0;
  logic [1:0] vote_id = 2'd0;
  logic [1:0] vote_data = 2'd0;
  logic       ballots_ready = 1'b0;

  logic       vote_ready, ballots_valid, err_bad_id, err_dup;
  logic [BALLOT_VEC_W-1:0] p_ballots;
  logic [3:0] voted_mask;
  logic [7:0] round_cnt;
  logic       timed_out;

  logic       vote_ready3, ballots_valid3, err_bad_id3, err_dup3;
  logic [5:0] p_ballots3;
  logic [2:0] voted_mask3;
  logic [7:0] round_cnt3;
  logic       timed_out3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  voting_ballot_collector #(
    .N_VOTERS(4), .VOTE_W(2), .ID_W(2)
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .vote_valid(vote_valid), .vote_ready(vote_ready),
    .vote_id(vote_id), .vote_data(vote_data), .ballots_valid(ballots_valid),
    .ballots_ready(ballots_ready), .p_ballots(p_ballots), .voted_mask(voted_mask),
    .err_bad_id(err_bad_id), .err_dup(err_dup), .round_cnt(round_cnt)
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    , .timed_out(timed_out)
`endif
  );

  voting_ballot_collector #(
    .N_VOTERS(3), .VOTE_W(2), .ID_W(2)
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .vote_valid(vote_valid), .vote_ready(vote_ready3),
    .vote_id(vote_id), .vote_data(vote_data), .ballots_valid(ballots_valid3),
    .ballots_ready(ballots_ready), .p_ballots(p_ballots3), .voted_mask(voted_mask3),
    .err_bad_id(err_bad_id3), .err_dup(err_dup3), .round_cnt(round_cnt3)
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    , .timed_out(timed_out3)
`endif
  );

`ifndef VOTING_COLLECTOR_TIMEOUT_EN
  assign timed_out  = 1'b0;
  assign timed_out3 = 1'b0;
`endif

  // ---------------- reference model (4-voter instance) ----------------
  int m_ballot[4];
  bit m_voted[4];
  bit m_present;
  int m_round;
  bit m_eb, m_ed, m_to, m_started;
  int m_el;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin m_ballot[k] = 0; m_voted[k] = 1'b0; end
    m_present = 1'b0; m_round = 0; m_eb = 1'b0; m_ed = 1'b0;
    m_to = 1'b0; m_started = 1'b0; m_el = 0;
  endfunction

  // Effect of one clock edge given the inputs present at that edge.
  function automatic void model_step(bit vv, int id, int data, bit br);
    bit acc, first, all, fire;
    m_eb = 1'b0; m_ed = 1'b0;
    if (m_present) begin
      if (br) begin
        for (int k = 0; k < 4; k++) begin m_ballot[k] = 0; m_voted[k] = 1'b0; end
        m_present = 1'b0; m_round = (m_round + 1) % 256;
        m_to = 1'b0; m_started = 1'b0; m_el = 0;
      end
    end else begin
      acc = 1'b0; first = 1'b1; all = 1'b1; fire = 1'b0;
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
      fire = m_started && (m_el == TO - 1);
`endif
      for (int k = 0; k < 4; k++) if (m_voted[k]) first = 1'b0;
      if (vv) begin
        if (id >= 4) m_eb = 1'b1;
        else if (m_voted[id]) m_ed = 1'b1;
        else begin acc = 1'b1; m_ballot[id] = data; m_voted[id] = 1'b1; end
      end
      for (int k = 0; k < 4; k++) if (!m_voted[k]) all = 1'b0;
      if (acc && all) m_present = 1'b1;
      else if (fire) begin m_present = 1'b1; m_to = 1'b1; end
      if (acc && first) begin m_started = 1'b1; m_el = 1; end
      else if (m_started) m_el = m_el + 1;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [7:0] pb;
    logic [3:0] mk;
    for (int k = 0; k < 4; k++) begin
      pb[2*k +: 2] = 2'(m_ballot[k]);
      mk[k] = m_voted[k];
    end
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    return {m_to, !m_present, m_present, pb, mk, m_eb, m_ed, 8'(m_round)};
`else
    return {!m_present, m_present, pb, mk, m_eb, m_ed, 8'(m_round)};
`endif
  endfunction

  function automatic logic [VW-1:0] obs_vec();
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    return {timed_out, vote_ready, ballots_valid, p_ballots, voted_mask, err_bad_id, err_dup, round_cnt};
`else
    return {vote_ready, ballots_valid, p_ballots, voted_mask, err_bad_id, err_dup, round_cnt};
`endif
  endfunction

  // Drive inputs, advance the model, and land 1 ns after the edge.
  task automatic tick(input bit vv, input int id, input int data, input bit br);
    vote_valid = vv; vote_id = 2'(id); vote_data = 2'(data); ballots_ready = br;
    model_step(vv, id, data, br);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    vote_valid = 1'b0; ballots_ready = 1'b0;
    rst_n = 1'b0; model_reset();
    #3 rst_n = 1'b1;
    model_step(1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    #2;
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset got %h want %h", obs_vec(), exp_vec());
    end
    do_reset();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_release got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    int ids[4] = '{0, 1, 2, 3};
    int dat[4] = '{1, 2, 1, 3};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, ids[i], dat[i], 1'b0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL basic_step%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if (ballots_valid !== 1'b1 || p_ballots !== 8'b11_01_10_01 || voted_mask !== 4'b1111) begin
      n_err++; $display("FAIL basic_present valid=%b p=%b mask=%b want 1 11011001 1111",
                        ballots_valid, p_ballots, voted_mask);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, i % 4, $urandom_range(0, 3), 1'b0);
      n_vec++;
      if (obs_vec() !== exp_vec() || vote_ready !== 1'b0 || p_ballots !== 8'b11_01_10_01) begin
        n_err++; $display("FAIL hold_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tick(1'b1, 2, 2, 1'b1);
    n_vec++;
    if (obs_vec() !== exp_vec() || voted_mask !== 4'b0000 || round_cnt !== 8'd1 || vote_ready !== 1'b1) begin
      n_err++; $display("FAIL release got %h want %h", obs_vec(), exp_vec());
    end
    // First ballot after release is taken right away.
    tick(1'b1, 2, 2, 1'b0);
    n_vec++;
    if (obs_vec() !== exp_vec() || voted_mask !== 4'b0100) begin
      n_err++; $display("FAIL back_to_back got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_dup();
    do_reset();
    tick(1'b1, 1, 2, 1'b0);
    tick(1'b1, 1, 1, 1'b0);
    n_vec++;
    if (obs_vec() !== exp_vec() || err_dup !== 1'b1 || p_ballots[3:2] !== 2'b10 || voted_mask !== 4'b0010) begin
      n_err++; $display("FAIL dup got %h want %h", obs_vec(), exp_vec());
    end
    tick(1'b0, 0, 0, 1'b0);
    n_vec++;
    if (obs_vec() !== exp_vec() || err_dup !== 1'b0) begin
      n_err++; $display("FAIL dup_pulse got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_bad_id();
    logic [5:0] exp3;
    do_reset();
    tick(1'b1, 3, 2, 1'b0);
    n_vec++;
    if (err_bad_id3 !== 1'b1 || voted_mask3 !== 3'b000 || p_ballots3 !== 6'd0 || ballots_valid3 !== 1'b0 || err_dup3 !== 1'b0) begin
      n_err++; $display("FAIL bad_id err=%b mask=%b p=%b want 1 000 000000", err_bad_id3, voted_mask3, p_ballots3);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL id3_on_n4 got %h want %h", obs_vec(), exp_vec());
    end
    exp3 = 6'd0;
    for (int i = 0; i < 3; i++) begin
      int d;
      d = $urandom_range(0, 3);
      exp3[2*i +: 2] = 2'(d);
      tick(1'b1, i, d, 1'b0);
      if (i == 0) begin
        n_vec++;
        if (err_bad_id3 !== 1'b0 || voted_mask3 !== 3'b001) begin
          n_err++; $display("FAIL bad_id_pulse err=%b mask=%b want 0 001", err_bad_id3, voted_mask3);
        end
      end
    end
    n_vec++;
    if (ballots_valid3 !== 1'b1 || p_ballots3 !== exp3 || vote_ready3 !== 1'b0) begin
      n_err++; $display("FAIL n3_present valid=%b p=%b want 1 %b", ballots_valid3, p_ballots3, exp3);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL n4_after_bad got %h want %h", obs_vec(), exp_vec());
    end
    tick(1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 0, 3, 1'b0);
    tick(1'b1, 2, 1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_vec() !== exp_vec() || voted_mask !== 4'b0000 || p_ballots !== 8'd0) begin
      n_err++; $display("FAIL reset_mid got %h want %h", obs_vec(), exp_vec());
    end
    vote_valid = 1'b0;
    #2 rst_n = 1'b1;
    model_step(1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    tick(1'b1, 3, 2, 1'b0);
    n_vec++;
    if (obs_vec() !== exp_vec() || voted_mask !== 4'b1000) begin
      n_err++; $display("FAIL restart got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2) == 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef VOTING_COLLECTOR_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    tick(1'b1, 0, 1, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      tick(1'b0, 0, 0, 1'b0);
      n_vec++;
      if (obs_vec() !== exp_vec() || ballots_valid !== (i == TO - 2)) begin
        n_err++; $display("FAIL timeout_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if (p_ballots !== 8'b00_00_00_01 || timed_out !== 1'b1) begin
      n_err++; $display("FAIL timeout_present p=%b to=%b want 00000001 1", p_ballots, timed_out);
    end
    tick(1'b0, 0, 0, 1'b1);
    n_vec++;
    if (obs_vec() !== exp_vec() || timed_out !== 1'b0) begin
      n_err++; $display("FAIL timeout_release got %h want %h", obs_vec(), exp_vec());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_dup();
    test_bad_id();
    test_reset_mid();
`ifdef VOTING_COLLECTOR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
